// File: rtl/framer_ctrl.sv
// rtl/framer_ctrl.sv - Sequencer that feeds one payload plus auth tag and status fields into a framer
//
// Purpose:
//   Accepts a 512-bit payload, requests an 8-bit auth tag from a MAC engine,
//   strobes the framer with payload, message counter, timer and state bits,
//   waits out the framer latency and then presents the framed word until the
//   downstream side accepts it.
//
// Parameters:
//   FRAMER_LAT  - cycles from frm_load to a valid framer output (must be >= 1)
//   MAC_TIMEOUT - maximum cycles spent in MAC waiting for mac_done (>= 1)
//
// Optional feature macro:
//   FRAMER_CTRL_TIMEOUT_EN - when defined, MAC gives up after MAC_TIMEOUT
//   cycles and pulses err_timeout; otherwise MAC waits forever.
//
// Ports:
//   clk, reset                 - clock (rising edge), synchronous active-high reset
//   msg_valid/msg_ready/msg_data - payload handshake, accepted only in IDLE
//   tick                       - one-cycle timer increment pulse
//   mac_req/mac_done/mac_tag   - auth tag request, one-cycle done pulse, tag
//   frm_data, frm_msg_counter, frm_timer, frm_auth_tag, frm_state_bits
//                              - framer inputs, stable while the frame is in flight
//   frm_load                   - one-cycle framer capture strobe
//   frame_valid/frame_ready    - framed word handshake towards downstream
//   busy                       - controller is not in IDLE
//   err_timeout                - one-cycle MAC timeout pulse
module framer_ctrl #(
  parameter int FRAMER_LAT  = 1,
  parameter int MAC_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [511:0] msg_data,
  input  logic         tick,
  output logic         mac_req,
  input  logic         mac_done,
  input  logic [7:0]   mac_tag,
  output logic [511:0] frm_data,
  output logic [7:0]   frm_msg_counter,
  output logic [7:0]   frm_timer,
  output logic [7:0]   frm_auth_tag,
  output logic [1:0]   frm_state_bits,
  output logic         frm_load,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic         busy,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_SEND = 3'd4
  } state_e;

  // WAIT counts 0 .. FRAMER_LAT-1, so it needs to hold FRAMER_LAT-1.
  localparam int WAIT_W = (FRAMER_LAT > 1) ? $clog2(FRAMER_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FRAMER_LAT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]        msg_cnt_q, msg_cnt_d;
  logic [7:0]        timer_q, timer_d;
  logic              first_q, first_d;
  logic [511:0]      data_q, data_d;
  logic [7:0]        auth_q, auth_d;
  logic [7:0]        smp_cnt_q, smp_cnt_d;
  logic [7:0]        smp_tmr_q, smp_tmr_d;
  logic [1:0]        smp_bits_q, smp_bits_d;

  logic msg_accept;
  logic mac_hit;
  logic frame_done;
  logic mac_expired;

  logic msg_ready_c;
  logic mac_req_c;
  logic frm_load_c;
  logic frame_valid_c;
  logic err_timeout_c;

  // ------------------------------------------------------------------
  // MAC timeout
  // ------------------------------------------------------------------
`ifdef FRAMER_CTRL_TIMEOUT_EN
  localparam int TO_W = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MAC_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts cycles spent in MAC; cleared whenever the FSM is elsewhere so
  // every request starts a fresh window.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_MAC) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Asserted during the MAC_TIMEOUT-th cycle in MAC.
  assign mac_expired = (state_q == ST_MAC) && (to_cnt_q == TO_LAST);
`else
  localparam int unused_mac_timeout = MAC_TIMEOUT;
  assign mac_expired = 1'b0;
`endif

  // ------------------------------------------------------------------
  // FSM next state and strobes
  // ------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    msg_accept    = 1'b0;
    mac_hit       = 1'b0;
    frame_done    = 1'b0;
    msg_ready_c   = 1'b0;
    mac_req_c     = 1'b0;
    frm_load_c    = 1'b0;
    frame_valid_c = 1'b0;
    err_timeout_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        msg_ready_c = 1'b1;
        if (msg_valid) begin
          msg_accept = 1'b1;
          state_d    = ST_MAC;
        end
      end

      ST_MAC: begin
        mac_req_c = 1'b1;
        // A tag arriving in the timeout cycle still wins.
        if (mac_done) begin
          mac_hit = 1'b1;
          state_d = ST_LOAD;
        end else if (mac_expired) begin
          err_timeout_c = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_LOAD: begin
        frm_load_c = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_SEND: begin
        frame_valid_c = 1'b1;
        if (frame_ready) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath next state
  // ------------------------------------------------------------------
  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    timer_d    = timer_q;
    first_d    = first_q;
    data_d     = data_q;
    auth_d     = auth_q;
    smp_cnt_d  = smp_cnt_q;
    smp_tmr_d  = smp_tmr_q;
    smp_bits_d = smp_bits_q;

    if (tick) begin
      timer_d = timer_q + 8'd1;
    end

    if (msg_accept) begin
      data_d = msg_data;
    end

    // Framer fields are captured on the edge that enters LOAD. The timer is
    // sampled from the register, so a coincident tick is not yet visible.
    if (mac_hit) begin
      auth_d    = mac_tag;
      smp_cnt_d = msg_cnt_q;
      smp_tmr_d = timer_q;
      if (first_q) begin
        smp_bits_d = 2'b01;
      end else if (msg_cnt_q == 8'd0) begin
        smp_bits_d = 2'b10;
      end else begin
        smp_bits_d = 2'b00;
      end
    end

    if (frame_done) begin
      msg_cnt_d = msg_cnt_q + 8'd1;
      first_d   = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      msg_cnt_q  <= 8'd0;
      timer_q    <= 8'd0;
      first_q    <= 1'b1;
      data_q     <= '0;
      auth_q     <= 8'd0;
      smp_cnt_q  <= 8'd0;
      smp_tmr_q  <= 8'd0;
      smp_bits_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      msg_cnt_q  <= msg_cnt_d;
      timer_q    <= timer_d;
      first_q    <= first_d;
      data_q     <= data_d;
      auth_q     <= auth_d;
      smp_cnt_q  <= smp_cnt_d;
      smp_tmr_q  <= smp_tmr_d;
      smp_bits_q <= smp_bits_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Strobes are masked while reset is asserted so nothing handshakes in the
  // reset cycle regardless of the pre-reset state.
  assign msg_ready       = msg_ready_c   & ~reset;
  assign mac_req         = mac_req_c     & ~reset;
  assign frm_load        = frm_load_c    & ~reset;
  assign frame_valid     = frame_valid_c & ~reset;
  assign err_timeout     = err_timeout_c & ~reset;
  assign busy            = (state_q != ST_IDLE);

  assign frm_data        = data_q;
  assign frm_auth_tag    = auth_q;
  assign frm_msg_counter = smp_cnt_q;
  assign frm_timer       = smp_tmr_q;
  assign frm_state_bits  = smp_bits_q;

endmodule

// File: tb/tb_framer_ctrl.sv
// tb/tb_framer_ctrl.sv - Self-checking bench for framer_ctrl
module tb_framer_ctrl;

  localparam int LAT = 1;
  localparam int TMO = 4;

  logic         clk;
  logic         reset;
  logic         msg_valid;
  logic         msg_ready;
  logic [511:0] msg_data;
  logic         tick;
  logic         mac_req;
  logic         mac_done;
  logic [7:0]   mac_tag;
  logic [511:0] frm_data;
  logic [7:0]   frm_msg_counter;
  logic [7:0]   frm_timer;
  logic [7:0]   frm_auth_tag;
  logic [1:0]   frm_state_bits;
  logic         frm_load;
  logic         frame_valid;
  logic         frame_ready;
  logic         busy;
  logic         err_timeout;

  framer_ctrl #(.FRAMER_LAT(LAT), .MAC_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .msg_valid       (msg_valid),
    .msg_ready       (msg_ready),
    .msg_data        (msg_data),
    .tick            (tick),
    .mac_req         (mac_req),
    .mac_done        (mac_done),
    .mac_tag         (mac_tag),
    .frm_data        (frm_data),
    .frm_msg_counter (frm_msg_counter),
    .frm_timer       (frm_timer),
    .frm_auth_tag    (frm_auth_tag),
    .frm_state_bits  (frm_state_bits),
    .frm_load        (frm_load),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: frames completed mod 256, first-frame flag, tick count.
  logic [7:0] m_cnt;
  logic       m_first;
  logic [7:0] m_timer;
  int         acc_cnt = 0;
  int         err_cnt = 0;
  bit         tick_rand = 1'b0;

  always @(posedge clk) begin
    if (reset) m_timer <= 8'd0;
    else if (tick) m_timer <= m_timer + 8'd1;
    if (msg_valid && msg_ready) acc_cnt <= acc_cnt + 1;
    if (err_timeout) err_cnt <= err_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "bench hung");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] bits_exp();
    if (m_first) return 2'b01;
    if (m_cnt == 8'd0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    tick = tick_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; msg_valid = 1'b0; mac_done = 1'b0; frame_ready = 1'b0;
    mac_tag = 8'd0; msg_data = '0; tick = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_msg_ready", msg_ready, 0);
    check("rst_mac_req", mac_req, 0);
    check("rst_frm_load", frm_load, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_frm_data", frm_data, 0);
    check("rst_auth", frm_auth_tag, 0);
    check("rst_cnt", frm_msg_counter, 0);
    check("rst_timer", frm_timer, 0);
    check("rst_bits", frm_state_bits, 0);
    reset = 1'b0;
    #1;
    check("post_rst_msg_ready", msg_ready, 1);
    m_cnt = 8'd0;
    m_first = 1'b1;
    step();
  endtask

  // Runs one complete frame. Entered and left just after a rising edge with
  // the DUT in IDLE. e_tmr < 0 means take the expected timer from the model.
  task automatic do_frame(input logic [511:0] data, input logic [7:0] tag,
                          input int mac_dly, input int rdy_dly, input bit hold_valid,
                          input bit tick_on_done, input logic [7:0] e_cnt,
                          input int e_tmr, input logic [1:0] e_bits);
    logic [7:0] xt;
    msg_valid = 1'b1; msg_data = data; frame_ready = 1'b0; mac_done = 1'b0;
    @(negedge clk);
    check("idle_ready", msg_ready, 1);
    check("idle_busy", busy, 0);
    step();
    msg_valid = hold_valid; msg_data = rand512();
    for (int i = 0; i < mac_dly; i++) begin
      @(negedge clk);
      check("mac_req", mac_req, 1);
      check("mac_ready", msg_ready, 0);
      check("mac_err", err_timeout, 0);
      check("mac_busy", busy, 1);
      step();
      msg_data = rand512();
    end
    mac_done = 1'b1; mac_tag = tag;
    if (tick_on_done) tick = 1'b1;
    @(negedge clk);
    check("done_mac_req", mac_req, 1);
    check("done_err", err_timeout, 0);
    xt = (e_tmr < 0) ? m_timer : 8'(e_tmr);
    step();
    mac_done = 1'b0; mac_tag = 8'($urandom);
    @(negedge clk);
    check("load_strobe", frm_load, 1);
    check("load_mac_req", mac_req, 0);
    check("load_cnt", frm_msg_counter, e_cnt);
    check("load_timer", frm_timer, xt);
    check("load_bits", frm_state_bits, e_bits);
    check("load_auth", frm_auth_tag, tag);
    check("load_data", frm_data, data);
    for (int i = 0; i < LAT; i++) begin
      step();
      @(negedge clk);
      check("wait_load", frm_load, 0);
      check("wait_valid", frame_valid, 0);
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      step();
      frame_ready = (i == rdy_dly);
      @(negedge clk);
      check("send_valid", frame_valid, 1);
      check("send_ready", msg_ready, 0);
      check("send_data", frm_data, data);
      check("send_auth", frm_auth_tag, tag);
    end
    step();
    frame_ready = 1'b0;
    m_cnt = m_cnt + 8'd1;
    m_first = 1'b0;
  endtask

  typedef struct {
    logic [511:0] data;
    logic [7:0]   tag;
    int           mac_dly;
    int           rdy_dly;
    logic [7:0]   e_cnt;
    int           e_tmr;
    logic [1:0]   e_bits;
  } vec_t;

  vec_t vecs[3];
  int   a0;

  initial begin
    vecs[0] = '{512'h2AA, 8'hF0, 2, 0, 8'h00, 0, 2'b01};
    vecs[1] = '{{16{32'hDEADBEEF}}, 8'hA5, 0, 1, 8'h01, 0, 2'b00};
    vecs[2] = '{{8{64'h0123456789ABCDEF}}, 8'h3C, 1, 2, 8'h02, 0, 2'b00};

    do_reset();

    for (int i = 0; i < 3; i++) begin
      do_frame(vecs[i].data, vecs[i].tag, vecs[i].mac_dly, vecs[i].rdy_dly, 1'b0, 1'b0,
               vecs[i].e_cnt, vecs[i].e_tmr, vecs[i].e_bits);
    end

    // Bring the timer to 0x33, then tick in the cycle that enters LOAD.
    for (int i = 0; i < 51; i++) begin
      step();
      tick = 1'b1;
    end
    step();
    do_frame(rand512(), 8'h11, 1, 0, 1'b0, 1'b1, 8'h03, 8'h33, 2'b00);
    do_frame(rand512(), 8'h22, 0, 0, 1'b0, 1'b0, 8'h04, 8'h34, 2'b00);

    // msg_valid held through a frame with frame_ready low for 5 cycles.
    a0 = acc_cnt;
    do_frame(rand512(), 8'h33, 1, 5, 1'b1, 1'b0, m_cnt, -1, bits_exp());
    check("held_single_accept", acc_cnt, a0 + 1);
    do_frame(rand512(), 8'h44, 0, 0, 1'b0, 1'b0, m_cnt, -1, bits_exp());
    check("held_second_accept", acc_cnt, a0 + 2);

`ifdef FRAMER_CTRL_TIMEOUT_EN
    a0 = err_cnt;
    msg_valid = 1'b1; msg_data = rand512();
    step();
    msg_valid = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      check("to_mac_req", mac_req, 1);
      check("to_err", err_timeout, (i == TMO - 1));
      if (i < TMO - 1) step();
    end
    step();
    @(negedge clk);
    check("to_busy", busy, 0);
    check("to_err_off", err_timeout, 0);
    check("to_err_pulses", err_cnt, a0 + 1);
    step();
    do_frame(rand512(), 8'h55, 0, 0, 1'b0, 1'b0, m_cnt, -1, bits_exp());
`else
    do_frame(rand512(), 8'h55, 12, 0, 1'b0, 1'b0, m_cnt, -1, bits_exp());
    check("no_to_err_pulses", err_cnt, 0);
`endif

    // Reset while the frame is being offered downstream.
    msg_valid = 1'b1; msg_data = rand512();
    step();
    msg_valid = 1'b0; mac_done = 1'b1; mac_tag = 8'h66;
    step();
    mac_done = 1'b0;
    step();
    step();
    @(negedge clk);
    check("send_before_rst", frame_valid, 1);
    reset = 1'b1; frame_ready = 1'b1;
    step();
    reset = 1'b0; frame_ready = 1'b0;
    @(negedge clk);
    check("rst_send_busy", busy, 0);
    check("rst_send_valid", frame_valid, 0);
    m_cnt = 8'd0;
    m_first = 1'b1;
    step();

    // 256 random frames wrap the counter back to 0.
    tick_rand = 1'b1;
    for (int n = 0; n < 256; n++) begin
      do_frame(rand512(), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'b0, m_cnt, -1, bits_exp());
    end
    tick_rand = 1'b0;
    do_frame(rand512(), 8'h77, 1, 0, 1'b0, 1'b0, 8'h00, -1, 2'b10);
    do_frame(rand512(), 8'h88, 1, 0, 1'b0, 1'b0, 8'h01, -1, 2'b00);

    msg_valid = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
